// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode and count-direction encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_CNT_W_DEF = 16;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_t;

endpackage

// File: rtl/pwm_cmp_ch.sv
// One PWM channel: duty shadow register plus registered compare against the shared counter.
// Latency: pwm follows cnt by one clock; a duty_we write is seen by the compare on the next clock.
// Backpressure: none; duty_we is a single-cycle strobe from the top-level boundary logic.
module pwm_cmp_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             duty_we,
    input  logic [CNT_W-1:0] duty_nxt,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_sh;

    // Shadow duty update at period boundaries and registered compare (forced low while stopped).
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh <= '0;
            pwm     <= 1'b0;
        end else begin
            if (duty_we) begin
                duty_sh <= duty_nxt;
            end
            pwm <= en && (cnt < duty_sh);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: one shared period counter (edge or center aligned) with double-buffered period/duty/mode.
// Latency: pwm_out and period_tick are registered, one clock behind cnt; staged values apply at the next boundary.
// Backpressure: none; load is a one-cycle pulse that is always accepted (later loads overwrite staged values).
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = PWM_CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CNT_W-1:0]    period,
    input  logic [CH*CNT_W-1:0] duty,
    input  logic                center_mode,
    input  logic                load,
    output logic [CH-1:0]       pwm_out,
    output logic                period_tick,
    output logic                load_pending,
    output logic [CNT_W-1:0]    cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    pwm_dir_t            dir_q, dir_d;
    logic                tick_q, tick_d;
    logic                run_q;

    logic [CNT_W-1:0]    period_sh, stg_period, nxt_period;
    pwm_mode_t           mode_sh, stg_mode, in_mode;
    logic [CH*CNT_W-1:0] stg_duty, duty_src;
    logic                pend_q;

    logic                first_run, boundary, apply, bypass, shadow_we;

    assign in_mode   = center_mode ? PWM_CENTER : PWM_EDGE;
    assign first_run = en && !run_q;

    // Shadow transfer point: every cycle when P is 0, cnt==P in edge mode, return to 0 (or run start) in center mode.
    always_comb begin
        boundary = 1'b0;
        if (period_sh == '0) begin
            boundary = 1'b1;
        end else if (mode_sh == PWM_EDGE) begin
            boundary = (cnt_q == period_sh);
        end else begin
            boundary = (cnt_q == '0) && ((dir_q == DIR_DOWN) || first_run);
        end
    end

    // While stopped there is no period to protect, so every cycle behaves as a boundary.
    assign apply      = !en || boundary;
    assign bypass     = apply && load;
    assign shadow_we  = apply && (load || pend_q);
    assign nxt_period = bypass ? period : (shadow_we ? stg_period : period_sh);
    assign duty_src   = bypass ? duty : stg_duty;

    // Counter / direction next state; the center-mode turn at 0 uses the period that is about to be shadowed.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if ((period_sh == '0) || ((mode_sh == PWM_EDGE) && (cnt_q == period_sh))) begin
            cnt_d  = '0;
            dir_d  = DIR_UP;
            tick_d = 1'b1;
        end else if (mode_sh == PWM_EDGE) begin
            cnt_d = cnt_q + ONE;
        end else if (boundary) begin
            cnt_d = (nxt_period == '0) ? '0 : ONE;
            dir_d = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == period_sh) begin
                cnt_d  = cnt_q - ONE;
                dir_d  = DIR_DOWN;
                tick_d = (cnt_q == ONE);
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end else begin
            cnt_d  = cnt_q - ONE;
            tick_d = (cnt_q == ONE);
        end
    end

    // Counter, direction, tick and run-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            tick_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tick_q <= tick_d;
            run_q  <= en;
        end
    end

    // Staging and shadow registers for period/mode; a load at a boundary goes straight to the shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_sh  <= '0;
            mode_sh    <= PWM_EDGE;
            stg_period <= '0;
            stg_mode   <= PWM_EDGE;
            stg_duty   <= '0;
            pend_q     <= 1'b0;
        end else if (shadow_we) begin
            period_sh <= nxt_period;
            mode_sh   <= bypass ? in_mode : stg_mode;
            pend_q    <= 1'b0;
        end else if (load) begin
            stg_period <= period;
            stg_duty   <= duty;
            stg_mode   <= in_mode;
            pend_q     <= 1'b1;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pwm_cmp_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .cnt      (cnt_q),
            .duty_we  (shadow_we),
            .duty_nxt (duty_src[i*CNT_W +: CNT_W]),
            .pwm      (pwm_out[i])
        );
    end

    assign cnt          = cnt_q;
    assign period_tick  = tick_q;
    assign load_pending = pend_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch (CH=4, CNT_W=8).
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pwm_multi_ch;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [CNT_W-1:0]    period;
    logic [CH*CNT_W-1:0] duty;
    logic                center_mode;
    logic                load;
    logic [CH-1:0]       pwm_out;
    logic                period_tick;
    logic                load_pending;
    logic [CNT_W-1:0]    cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_multi_ch #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .period       (period),
        .duty         (duty),
        .center_mode  (center_mode),
        .load         (load),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .load_pending (load_pending),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Center-mode counter value after m clocks from the run start (period 16, P=8).
    function automatic int cfold(int m);
        int r;
        r = m % 16;
        return (r <= 8) ? r : 16 - r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; period = '0; duty = '0; center_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst = 1'b0;
            step();
            n_tests++;
            if ({pwm_out, period_tick, load_pending, cnt} !== 15'd0) begin
                n_fail++;
                $display("FAIL reset/idle i=%0d: pwm=%b tick=%b pend=%b cnt=%0d, want all 0",
                         i, pwm_out, period_tick, load_pending, cnt);
            end
        end
    endtask

    task automatic test_edge();
        logic [3:0] ep;
        logic [7:0] ec;
        logic       et;
        period = 8'd9; duty = {8'd12, 8'd5, 8'd3, 8'd0}; center_mode = 1'b0; load = 1'b1; en = 1'b0;
        step();
        n_tests++;
        if (load_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_load_while_stopped: pend=%b want 0", load_pending);
        end
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            ec = 8'((k + 1) % 10);
            et = (k % 10 == 9);
            ep = {1'b1, (k % 10) < 5, (k % 10) < 3, 1'b0};
            n_tests++;
            if ({pwm_out, period_tick, cnt} !== {ep, et, ec}) begin
                n_fail++;
                $display("FAIL edge k=%0d: pwm=%b tick=%b cnt=%0d, want pwm=%b tick=%b cnt=%0d",
                         k, pwm_out, period_tick, cnt, ep, et, ec);
            end
        end
    endtask

    task automatic test_center();
        logic [3:0] ep;
        logic [7:0] ec;
        logic       et;
        int         hi = 0;
        int         ticks = 0;
        period = 8'd8; duty = {24'd0, 8'd4}; center_mode = 1'b1; load = 1'b1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            step();
            ec = 8'(cfold(k + 1));
            et = (cfold(k + 1) == 0);
            ep = {3'b000, cfold(k) < 4};
            if (k < 16 && pwm_out[0]) hi++;
            if (period_tick) ticks++;
            n_tests++;
            if ({pwm_out, period_tick, cnt} !== {ep, et, ec}) begin
                n_fail++;
                $display("FAIL center k=%0d: pwm=%b tick=%b cnt=%0d, want pwm=%b tick=%b cnt=%0d",
                         k, pwm_out, period_tick, cnt, ep, et, ec);
            end
        end
        n_tests++;
        if (hi != 7) begin
            n_fail++;
            $display("FAIL center_high_time: %0d clocks, want 7", hi);
        end
        n_tests++;
        if (ticks != 2) begin
            n_fail++;
            $display("FAIL center_tick_count: %0d, want 2", ticks);
        end
    endtask

    task automatic test_glitch_free();
        logic ep1, epend;
        period = 8'd9; duty = {8'd12, 8'd5, 8'd3, 8'd0}; center_mode = 1'b0; load = 1'b1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            ep1   = (k % 10) < ((k >= 10) ? 7 : 3);
            epend = (k >= 4 && k <= 8);
            n_tests++;
            if ({pwm_out[1], load_pending, period_tick, cnt} !== {ep1, epend, k % 10 == 9, 8'((k + 1) % 10)}) begin
                n_fail++;
                $display("FAIL glitch_free k=%0d: pwm1=%b pend=%b tick=%b cnt=%0d, want pwm1=%b pend=%b",
                         k, pwm_out[1], load_pending, period_tick, cnt, ep1, epend);
            end
            if (k == 3) begin
                duty[15:8] = 8'd7;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ep1, epend;
        int   d1;
        for (int k = 20; k < 50; k++) begin
            step();
            d1    = (k < 30) ? 7 : ((k < 40) ? 2 : 6);
            ep1   = (k % 10) < d1;
            epend = (k >= 33 && k <= 38);
            n_tests++;
            if ({pwm_out[1], load_pending, cnt} !== {ep1, epend, 8'((k + 1) % 10)}) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d: pwm1=%b pend=%b cnt=%0d, want pwm1=%b pend=%b cnt=%0d",
                         k, pwm_out[1], load_pending, cnt, ep1, epend, (k + 1) % 10);
            end
            load = 1'b0;
            if (k == 28) begin duty[15:8] = 8'd2; load = 1'b1; end
            if (k == 32) begin duty[15:8] = 8'd4; load = 1'b1; end
            if (k == 33) begin duty[15:8] = 8'd6; load = 1'b1; end
        end
        load = 1'b0;
    endtask

    task automatic test_corners();
        // P=0, duty=1: constant high, tick every cycle
        period = 8'd0; duty = {24'd0, 8'd1}; center_mode = 1'b0; load = 1'b1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if ({pwm_out, period_tick, cnt} !== {4'b0001, 1'b1, 8'd0}) begin
                n_fail++;
                $display("FAIL p0 k=%0d: pwm=%b tick=%b cnt=%0d, want pwm=0001 tick=1 cnt=0",
                         k, pwm_out, period_tick, cnt);
            end
        end
        // en dropped mid-period
        period = 8'd9; duty = {8'd12, 8'd5, 8'd3, 8'd0}; load = 1'b1; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 5; k++) step();
        n_tests++;
        if ({pwm_out, cnt} !== {4'b1100, 8'd5}) begin
            n_fail++;
            $display("FAIL en_drop_before: pwm=%b cnt=%0d, want pwm=1100 cnt=5", pwm_out, cnt);
        end
        en = 1'b0;
        step();
        n_tests++;
        if ({pwm_out, period_tick, cnt} !== 13'd0) begin
            n_fail++;
            $display("FAIL en_drop_after: pwm=%b tick=%b cnt=%0d, want all 0", pwm_out, period_tick, cnt);
        end
        // rst mid-period with a staged load outstanding
        en = 1'b1;
        for (int k = 0; k < 3; k++) step();
        n_tests++;
        if ({pwm_out, cnt} !== {4'b1110, 8'd3}) begin
            n_fail++;
            $display("FAIL rst_before: pwm=%b cnt=%0d, want pwm=1110 cnt=3", pwm_out, cnt);
        end
        period = 8'd5; duty = {8'd1, 8'd1, 8'd1, 8'd1}; load = 1'b1;
        step();
        n_tests++;
        if (load_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_staged: pend=%b want 1", load_pending);
        end
        load = 1'b0; rst = 1'b1;
        step();
        n_tests++;
        if ({pwm_out, period_tick, load_pending, cnt} !== 15'd0) begin
            n_fail++;
            $display("FAIL rst_mid: pwm=%b tick=%b pend=%b cnt=%0d, want all 0",
                     pwm_out, period_tick, load_pending, cnt);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({pwm_out, period_tick, load_pending, cnt} !== {4'b0000, 1'b1, 1'b0, 8'd0}) begin
                n_fail++;
                $display("FAIL rst_cleared k=%0d: pwm=%b tick=%b pend=%b cnt=%0d, want pwm=0 tick=1 pend=0 cnt=0",
                         k, pwm_out, period_tick, load_pending, cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_glitch_free();
        test_back_to_back();
        test_corners();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
